// File: rtl/legv8_operand_fetch.sv
// legv8_operand_fetch: register-read stage feeding the LEGv8 64-bit ALU.
// Holds the 32-entry register file (X31 reads as XZR). It reads two sources
// with same-cycle writeback bypass and can substitute an immediate for B.
// The op/A/B values are captured into a valid/ready output register.
module legv8_operand_fetch #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     rn,
  input  logic [AW-1:0]     rm,
  input  logic [3:0]        alu_op,
  input  logic              imm_sel,
  input  logic [DATA_W-1:0] imm,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        ALUoperation,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              op_illegal
);

  localparam logic [AW-1:0] XZR = AW'(NUM_REGS - 1);

  // Operation codes the downstream ALU implements: AND, ORR, ADD, SUB, pass-B, NOR.
  function automatic logic op_is_illegal(input logic [3:0] op);
    logic ill;
    case (op)
      4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12: ill = 1'b0;
      default:                             ill = 1'b1;
    endcase
    return ill;
  endfunction

  logic [DATA_W-1:0] regs_r [NUM_REGS];
  logic [DATA_W-1:0] rn_val_s;
  logic [DATA_W-1:0] rm_val_s;
  logic [DATA_W-1:0] b_val_s;
  logic              issue_s;
  logic              wb_write_s;

  assign in_ready   = !out_valid || out_ready;
  assign issue_s    = in_valid && in_ready;
  assign wb_write_s = wb_en && (wb_addr != XZR);

  // Register file: a synchronous clear of every entry, then writeback writes (X31 is never written).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wb_write_s) begin
      regs_r[wb_addr] <= wb_data;
    end
  end

  // Source A read: XZR first, then same-cycle writeback bypass, then the stored value.
  always_comb begin
    rn_val_s = '0;
    if (rn == XZR) begin
      rn_val_s = '0;
    end else if (wb_en && (wb_addr == rn)) begin
      rn_val_s = wb_data;
    end else begin
      rn_val_s = regs_r[rn];
    end
  end

  // Source B read: same priority as A; the immediate replaces it when imm_sel is set.
  always_comb begin
    rm_val_s = '0;
    if (rm == XZR) begin
      rm_val_s = '0;
    end else if (wb_en && (wb_addr == rm)) begin
      rm_val_s = wb_data;
    end else begin
      rm_val_s = regs_r[rm];
    end
    if (imm_sel) begin
      b_val_s = imm;
    end else begin
      b_val_s = rm_val_s;
    end
  end

  // Output register: load on issue. A transfer alone clears valid. A stall holds everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      ALUoperation <= 4'd0;
      A            <= '0;
      B            <= '0;
      op_illegal   <= 1'b0;
    end else if (issue_s) begin
      out_valid    <= 1'b1;
      ALUoperation <= alu_op;
      A            <= rn_val_s;
      B            <= b_val_s;
      op_illegal   <= op_is_illegal(alu_op);
    end else if (out_valid && out_ready) begin
      out_valid    <= 1'b0;
    end else begin
      out_valid    <= out_valid;
    end
  end

endmodule

// File: tb/tb_legv8_operand_fetch.sv
// Directed self-checking bench for legv8_operand_fetch.
module tb_legv8_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rn, rm;
  logic [3:0]  alu_op;
  logic        imm_sel;
  logic [63:0] imm;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  ALUoperation;
  logic [63:0] A, B;
  logic        op_illegal;

  int checks_s   = 0;
  int failures_s = 0;

  always #5 clk = ~clk;

  legv8_operand_fetch dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rn(rn), .rm(rm), .alu_op(alu_op), .imm_sel(imm_sel), .imm(imm),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .ALUoperation(ALUoperation),
    .A(A), .B(B), .op_illegal(op_illegal)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_s++;
    if (obs !== exp) begin
      failures_s++;
      $display("FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] a, input logic [4:0] b, input logic [3:0] op,
                       input logic sel, input logic [63:0] im);
    in_valid = 1'b1; rn = a; rm = b; alu_op = op; imm_sel = sel; imm = im;
  endtask

  task automatic wb(input logic en, input logic [4:0] ad, input logic [63:0] d);
    wb_en = en; wb_addr = ad; wb_data = d;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [63:0] ea,
                           input logic [63:0] eb, input logic [3:0] eop, input logic eill);
    check({tag, "_valid"}, {63'd0, out_valid}, {63'd0, v});
    check({tag, "_A"}, A, ea);
    check({tag, "_B"}, B, eb);
    check({tag, "_op"}, {60'd0, ALUoperation}, {60'd0, eop});
    check({tag, "_ill"}, {63'd0, op_illegal}, {63'd0, eill});
  endtask

  logic [4:0]  s_rn  [4] = '{5'd3, 5'd4, 5'd1, 5'd0};
  logic [63:0] s_a   [4] = '{64'hFF, 64'hDEAD_BEEF, 64'h55, 64'h0};
  logic [63:0] s_imm [4] = '{64'h11, 64'h2222, 64'h3_3333, 64'h44_4444};
  logic [3:0]  s_op  [4] = '{4'd2, 4'd6, 4'd7, 4'd12};

  initial begin
    reset = 1'b1; in_valid = 1'b0; rn = 5'd0; rm = 5'd0; alu_op = 4'd0;
    imm_sel = 1'b0; imm = 64'd0; out_ready = 1'b1;
    wb(1'b1, 5'd2, 64'h99);  // must be ignored under reset
    @(negedge clk);
    tick();
    reset = 1'b0; wb(1'b0, 5'd0, 64'd0);
    check_out("rst", 1'b0, 64'd0, 64'd0, 4'd0, 1'b0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Reset then reads
    issue(5'd5, 5'd7, 4'd2, 1'b0, 64'd0);
    tick();
    in_valid = 1'b0;
    check_out("rd0", 1'b1, 64'd0, 64'd0, 4'd2, 1'b0);

    // Write X3, then read with XZR
    wb(1'b1, 5'd3, 64'hFF);
    tick();
    wb(1'b0, 5'd0, 64'd0);
    check("xfer_drop_valid", {63'd0, out_valid}, 64'd0);
    issue(5'd3, 5'd31, 4'd0, 1'b0, 64'd0);
    tick();
    in_valid = 1'b0;
    check_out("x3", 1'b1, 64'hFF, 64'd0, 4'd0, 1'b0);

    // Write to X31 is discarded
    wb(1'b1, 5'd31, 64'h1234);
    tick();
    wb(1'b0, 5'd0, 64'd0);
    issue(5'd31, 5'd31, 4'd1, 1'b0, 64'd0);
    tick();
    in_valid = 1'b0;
    check_out("xzr", 1'b1, 64'd0, 64'd0, 4'd1, 1'b0);

    // Same-cycle bypass, rn==rm
    wb(1'b1, 5'd4, 64'hDEAD_BEEF);
    issue(5'd4, 5'd4, 4'd6, 1'b0, 64'd0);
    tick();
    wb(1'b0, 5'd0, 64'd0);
    in_valid = 1'b0;
    check_out("byp", 1'b1, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 4'd6, 1'b0);
    issue(5'd4, 5'd0, 4'd7, 1'b0, 64'd0);
    tick();
    in_valid = 1'b0;
    check_out("r4", 1'b1, 64'hDEAD_BEEF, 64'd0, 4'd7, 1'b0);

    // Immediate operand and illegal op
    wb(1'b1, 5'd1, 64'd10);
    tick();
    wb(1'b0, 5'd0, 64'd0);
    issue(5'd1, 5'd3, 4'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    imm_sel = 1'b0;
    check_out("imm", 1'b1, 64'd10, 64'hFFFF_FFFF_FFFF_FFFF, 4'd5, 1'b1);

    // Backpressure: pending issue plus writeback to its rn during the stall
    out_ready = 1'b0;
    issue(5'd1, 5'd3, 4'd12, 1'b0, 64'd0);
    wb(1'b1, 5'd1, 64'h55);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
      check_out("stall", 1'b1, 64'd10, 64'hFFFF_FFFF_FFFF_FFFF, 4'd5, 1'b1);
    end
    wb(1'b0, 5'd0, 64'd0);
    out_ready = 1'b1;
    #1;
    check("release_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    check_out("release", 1'b1, 64'h55, 64'hFF, 4'd12, 1'b0);

    // Streaming: four back-to-back issues
    for (int i = 0; i < 4; i++) begin
      issue(s_rn[i], 5'd0, s_op[i], 1'b1, s_imm[i]);
      tick();
      check_out($sformatf("stream%0d", i), 1'b1, s_a[i], s_imm[i], s_op[i], 1'b0);
    end
    in_valid = 1'b0; imm_sel = 1'b0;

    // Mid-operation reset with a simultaneous write that must be dropped
    reset = 1'b1;
    wb(1'b1, 5'd2, 64'h7);
    tick();
    reset = 1'b0;
    wb(1'b0, 5'd0, 64'd0);
    check_out("mid_rst", 1'b0, 64'd0, 64'd0, 4'd0, 1'b0);
    issue(5'd3, 5'd4, 4'd0, 1'b0, 64'd0);
    tick();
    check_out("post_rst_a", 1'b1, 64'd0, 64'd0, 4'd0, 1'b0);
    issue(5'd1, 5'd2, 4'd1, 1'b0, 64'd0);
    tick();
    in_valid = 1'b0;
    check_out("post_rst_b", 1'b1, 64'd0, 64'd0, 4'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_s, failures_s);
    $finish;
  end

endmodule

// File: doc/legv8_operand_fetch.md
Name: legv8_operand_fetch

Overview:
- Register-read stage directly upstream of the LEGv8 64-bit ALU.
- Holds the 32-entry architectural register file, with X31 as XZR. Reads two source registers and optionally substitutes an immediate for operand B.
- Captures the ALU operation code, A and B into a valid/ready output register that drives the ALU's ALUoperation/A/B inputs.
- Accepts writeback from later stages, with same-cycle write-to-read bypass.

Parameters:
- DATA_W, 64, operand and register width.
- NUM_REGS, 32, register count; address width is log2(NUM_REGS)=5. The highest index (31) is XZR.

Ports:
- clk  input  1  rising-edge clock, sole clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  issue request valid.
- in_ready  output  1  stage can accept the issue this cycle.
- rn  input  5  source register for A.
- rm  input  5  source register for B.
- alu_op  input  4  ALU operation code to forward.
- imm_sel  input  1  1: B = imm; 0: B = R[rm].
- imm  input  DATA_W  pre-extended immediate.
- wb_en  input  1  register write enable.
- wb_addr  input  5  write destination.
- wb_data  input  DATA_W  write data.
- out_valid  output  1  A/B/ALUoperation valid for the ALU.
- out_ready  input  1  ALU/downstream consumes this cycle.
- ALUoperation  output  4  registered alu_op.
- A  output  DATA_W  registered operand A.
- B  output  DATA_W  registered operand B.
- op_illegal  output  1  registered flag: captured alu_op not in {0,1,2,6,7,12}.

Behaviour:
- Reset (sync, reset=1 at a clk edge):
  - All registers R0..R30 = 0.
  - out_valid=0, ALUoperation=0, A=0, B=0, op_illegal=0.
  - Reset overrides any simultaneous wb_en or issue.
  - Reset mid-transfer drops the held output; nothing is replayed.
- Register file:
  - On a clk edge with wb_en=1 and wb_addr!=31, R[wb_addr] <= wb_data.
  - Writes to 31 are ignored.
  - Reads of index 31 return 0 always.
- Read value for rn (and likewise rm):
  - If rn==31: 0.
  - Else if wb_en && wb_addr==rn: wb_data (same-cycle bypass).
  - Else: R[rn].
- B source: imm_sel=1 gives imm, and rm is ignored.
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational and depends only on out_valid/out_ready, never on in_valid.
  - Issue fires when in_valid && in_ready. On that edge, A/B/ALUoperation/op_illegal are loaded and out_valid <= 1.
  - Output transfer occurs when out_valid && out_ready.
  - Transfer without a new issue: out_valid <= 0. A/B/ALUoperation hold their last values.
  - Transfer and issue in the same cycle: new values load, out_valid stays 1, giving one result per cycle with no bubble.
  - out_valid && !out_ready: all outputs hold stable and in_ready=0. A writeback during a stall does not update already-captured A/B.
- Latency: one clk from issue to out_valid. Throughput: one issue per cycle when out_ready is held high.
- op_illegal:
  - Set when the captured alu_op is outside {0,1,2,6,7,12}.
  - alu_op is still forwarded unchanged.
  - The flag is registered and valid only with out_valid.
- Simultaneous write and read of the same register: the reader gets the new data (bypass). The register file also updates that edge.
- rn==rm: both operands get the same value, including bypass.
- No overflow or width conversion; all data paths are DATA_W wide.

Test Plan:
- Reset then reads: assert reset 1 cycle, issue rn=5, rm=7, alu_op=2, imm_sel=0 -> next cycle out_valid=1, A=0, B=0, ALUoperation=2, op_illegal=0.
- Write/read and XZR:
  - wb X3=0x0000_0000_0000_00FF; next cycle issue rn=3, rm=31, op=0 -> A=0xFF, B=0.
  - wb X31=0x1234 then read 31 -> 0.
- Bypass: same cycle wb_en=1, wb_addr=4, wb_data=0xDEAD_BEEF and issue rn=4, rm=4, op=6 -> A=B=0xDEAD_BEEF. R4 then reads 0xDEAD_BEEF on later issues.
- Immediate and illegal op: R1=10, issue rn=1, imm_sel=1, imm=0xFFFF_FFFF_FFFF_FFFF, alu_op=5 -> A=10, B=all ones, ALUoperation=5, op_illegal=1.
- Backpressure:
  - Hold out_ready=0 with out_valid=1 for 3 cycles while in_valid=1 and wb to rn occurs -> in_ready=0, A/B/ALUoperation unchanged.
  - Raise out_ready -> transfer, and the pending issue loads the same edge with out_valid still 1.
- Streaming and mid-op reset:
  - 4 back-to-back issues with out_ready=1 -> 4 consecutive out_valid cycles with matching operands.
  - Assert reset with out_valid=1 -> next cycle out_valid=0, A=B=0, and all registers read 0.
